render_sequencer: RTL and testbench

RENDER_SEQUENCER -- requirements
Module: render_sequencer

---
 rtl/render_if.sv | 27 ++
 rtl/render_sequencer.sv | 144 ++++++++++++++
 tb/tb_render_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/render_if.sv
// Handshake and clear-port bundle between the render sequencer and its neighbours
// (triangle store, rasterizer, frame/Z buffers, frame controller).
interface render_if;
    logic        i_frame_start;
    logic [7:0]  i_tri_count;
    logic [7:0]  o_tri_idx;
    logic        o_tri_valid;
    logic        i_rast_busy;
    logic [16:0] o_clr_addr;
    logic        o_clr_we;
    logic [11:0] o_clr_pixel;
    logic [7:0]  o_clr_z;
    logic        o_busy;
    logic        o_frame_done;

    modport master (
        input  i_frame_start, i_tri_count, i_rast_busy,
        output o_tri_idx, o_tri_valid, o_clr_addr, o_clr_we,
               o_clr_pixel, o_clr_z, o_busy, o_frame_done
    );

    modport slave (
        output i_frame_start, i_tri_count, i_rast_busy,
        input  o_tri_idx, o_tri_valid, o_clr_addr, o_clr_we,
               o_clr_pixel, o_clr_z, o_busy, o_frame_done
    );
endinterface

// File: rtl/render_sequencer.sv
// Frame sequencer: clears frame/Z buffers, feeds triangles to the rasterizer one at a
// time with a valid/busy handshake, waits for the pipeline to drain, then pulses done.
module render_sequencer #(
    parameter int          NUM_PIXELS   = 76800,
    parameter logic [11:0] CLEAR_COLOR  = 12'h000,
    parameter logic [7:0]  CLEAR_Z      = 8'hFF,
    parameter int          DRAIN_CYCLES = 8
) (
    input  logic     i_clk,
    input  logic     i_rst,
    render_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CLEAR     = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] DRAIN     = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam logic [17:0] NUM_PIX_W  = 18'(NUM_PIXELS);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  tri_idx_q, tri_idx_d;
    logic        tri_valid_q, tri_valid_d;
    logic        clr_we_q, clr_we_d;
    logic [16:0] clr_addr_q, clr_addr_d;
    logic [17:0] clr_cnt_q, clr_cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        seen_low_q, seen_low_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tri_idx_d   = tri_idx_q;
        clr_addr_d  = clr_addr_q;
        clr_cnt_d   = clr_cnt_q;
        drain_cnt_d = drain_cnt_q;
        seen_low_d  = seen_low_q;
        clr_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_frame_start) begin
                    count_d    = bus.i_tri_count;
                    tri_idx_d  = 8'd0;
                    clr_cnt_d  = 18'd0;
                    clr_addr_d = 17'd0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                // One arming cycle, NUM_PIXELS writes, one settle cycle, then move on.
                clr_cnt_d = clr_cnt_q + 18'd1;
                if (clr_cnt_q < NUM_PIX_W) begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = clr_cnt_q[16:0];
                end else if (clr_cnt_q == NUM_PIX_W) begin
                    clr_addr_d = 17'd0;
                end else begin
                    drain_cnt_d = 16'd0;
                    state_d     = (count_q == 8'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                // A busy level seen here may be stale from the previous triangle.
                seen_low_d = ~bus.i_rast_busy;
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.i_rast_busy && seen_low_q) begin
                    state_d = WAIT_DONE;
                end else if (!bus.i_rast_busy) begin
                    seen_low_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.i_rast_busy) begin
                    tri_idx_d = tri_idx_q + 8'd1;
                    if (({1'b0, tri_idx_q} + 9'd1) == {1'b0, count_q}) begin
                        drain_cnt_d = 16'd0;
                        state_d     = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tri_valid_d  = (state_d == ISSUE) || (state_d == WAIT_ACK);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            count_q      <= 8'd0;
            tri_idx_q    <= 8'd0;
            tri_valid_q  <= 1'b0;
            clr_we_q     <= 1'b0;
            clr_addr_q   <= 17'd0;
            clr_cnt_q    <= 18'd0;
            drain_cnt_q  <= 16'd0;
            seen_low_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tri_idx_q    <= tri_idx_d;
            tri_valid_q  <= tri_valid_d;
            clr_we_q     <= clr_we_d;
            clr_addr_q   <= clr_addr_d;
            clr_cnt_q    <= clr_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            seen_low_q   <= seen_low_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.o_tri_idx    = tri_idx_q;
    assign bus.o_tri_valid  = tri_valid_q;
    assign bus.o_clr_addr   = clr_addr_q;
    assign bus.o_clr_we     = clr_we_q;
    assign bus.o_clr_pixel  = CLEAR_COLOR;
    assign bus.o_clr_z      = CLEAR_Z;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = frame_done_q;
endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer: clear sweep, triangle handshakes, stale busy,
// start-while-busy and mid-frame resets, on a reduced frame size.
module tb_render_sequencer;
    localparam int NP = 1100;
    localparam int D  = 8;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    render_if bus ();

    render_sequencer #(
        .NUM_PIXELS  (NP),
        .CLEAR_COLOR (12'h000),
        .CLEAR_Z     (8'hFF),
        .DRAIN_CYCLES(D)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Passive monitor sampled on the falling edge.
    int          wr_cnt = 0, addr_bad = 0, pix_bad = 0, over_cnt = 0;
    int          overlap = 0, done_cnt = 0, hs_cnt = 0;
    logic        prev_we = 1'b0, prev_valid = 1'b0;
    logic [16:0] prev_addr = 17'd0;

    always @(negedge clk) begin
        if (bus.o_clr_we === 1'b1) begin
            wr_cnt++;
            if (bus.o_clr_addr !== (prev_we ? prev_addr + 17'd1 : 17'd0)) addr_bad++;
            if (bus.o_clr_pixel !== 12'h000 || bus.o_clr_z !== 8'hFF) pix_bad++;
        end
        if (bus.o_clr_addr > 17'(NP - 1)) over_cnt++;
        if (bus.o_clr_we === 1'b1 && bus.o_tri_valid === 1'b1) overlap++;
        if (bus.o_frame_done === 1'b1) done_cnt++;
        if (bus.o_tri_valid === 1'b1 && !prev_valid) hs_cnt++;
        prev_we    = (bus.o_clr_we === 1'b1);
        prev_addr  = bus.o_clr_addr;
        prev_valid = (bus.o_tri_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] cnt, output int acc);
        bus.i_frame_start = 1'b1;
        bus.i_tri_count   = cnt;
        tick();
        acc = cyc;
        bus.i_frame_start = 1'b0;
        bus.i_tri_count   = 8'hA5;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.o_tri_valid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.o_tri_valid), 32'd1);
    endtask

    task automatic wait_addr(input logic [16:0] a, input string tag);
        int n = 0;
        while (!(bus.o_clr_we === 1'b1 && bus.o_clr_addr == a) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.o_clr_addr), 32'(a));
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (bus.o_frame_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(bus.o_clr_we),     32'd0);
        check({tag, "_valid"}, 32'(bus.o_tri_valid),  32'd0);
        check({tag, "_busy"},  32'(bus.o_busy),       32'd0);
        check({tag, "_done"},  32'(bus.o_frame_done), 32'd0);
        check({tag, "_addr"},  32'(bus.o_clr_addr),   32'd0);
        check({tag, "_idx"},   32'(bus.o_tri_idx),    32'd0);
        check({tag, "_pix"},   32'(bus.o_clr_pixel),  32'h000);
        check({tag, "_z"},     32'(bus.o_clr_z),      32'hFF);
    endtask

    initial begin
        int acc, at, b, w, dn, hs;
        rst = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_tri_count   = 8'd0;
        bus.i_rast_busy   = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Clear sweep with zero triangles.
        w = wr_cnt;
        start_frame(8'd0, acc);
        check("sweep_busy", 32'(bus.o_busy), 32'd1);
        check("sweep_arm_we", 32'(bus.o_clr_we), 32'd0);
        wait_done(NP + 100, at);
        check("sweep_latency", 32'(at - acc), 32'(NP + D + 2));
        check("sweep_writes", 32'(wr_cnt - w), 32'(NP));
        check("sweep_contig", 32'(addr_bad), 32'd0);
        check("sweep_pixel", 32'(pix_bad), 32'd0);
        tick();
        check("sweep_idle_busy", 32'(bus.o_busy), 32'd0);
        check("sweep_idle_done", 32'(bus.o_frame_done), 32'd0);

        // Three triangles, with an ignored start pulse mid-clear.
        dn = done_cnt;
        hs = hs_cnt;
        start_frame(8'd3, acc);
        wait_addr(17'd1000, "wait_addr1000");
        bus.i_frame_start = 1'b1;
        bus.i_tri_count   = 8'd9;
        tick();
        bus.i_frame_start = 1'b0;
        check("restart_busy", 32'(bus.o_busy), 32'd1);
        check("restart_addr", 32'(bus.o_clr_addr), 32'd1001);
        check("restart_we", 32'(bus.o_clr_we), 32'd1);
        b = 0;
        for (int i = 0; i < 3; i++) begin
            wait_valid("tri_valid");
            check("tri_idx", 32'(bus.o_tri_idx), 32'(i));
            tick();
            tick();
            bus.i_rast_busy = 1'b1;
            tick();
            check("tri_ack_drop", 32'(bus.o_tri_valid), 32'd0);
            repeat (49) tick();
            bus.i_rast_busy = 1'b0;
            b = cyc;
        end
        wait_done(50, at);
        check("tri_done_lat", 32'(at - b), 32'(D + 1));
        check("tri_final_idx", 32'(bus.o_tri_idx), 32'd3);
        tick();
        check("tri_handshakes", 32'(hs_cnt - hs), 32'd3);
        check("tri_done_once", 32'(done_cnt - dn), 32'd1);
        check("tri_no_overlap", 32'(overlap), 32'd0);
        check("tri_idx_hold", 32'(bus.o_tri_idx), 32'd3);

        // Stale busy: rasterizer already busy when the triangle is issued.
        bus.i_rast_busy = 1'b1;
        start_frame(8'd1, acc);
        wait_valid("stale_valid");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stale_hold_hi", 32'(bus.o_tri_valid), 32'd1);
        end
        bus.i_rast_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stale_hold_lo", 32'(bus.o_tri_valid), 32'd1);
        end
        bus.i_rast_busy = 1'b1;
        tick();
        check("stale_fresh_ack", 32'(bus.o_tri_valid), 32'd0);
        repeat (5) tick();
        bus.i_rast_busy = 1'b0;
        wait_done(50, at);
        check("stale_done_seen", 32'(at > 0), 32'd1);
        check("stale_final_idx", 32'(bus.o_tri_idx), 32'd1);
        tick();

        // Reset during CLEAR at address 500.
        start_frame(8'd2, acc);
        wait_addr(17'd500, "wait_addr500");
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_clear");
        rst = 1'b0;
        w  = wr_cnt;
        dn = done_cnt;
        repeat (20) tick();
        check("rst_clear_nowr", 32'(wr_cnt - w), 32'd0);
        check("rst_clear_nodone", 32'(done_cnt - dn), 32'd0);

        // Reset during WAIT_DONE.
        start_frame(8'd2, acc);
        wait_valid("rst_wd_valid");
        tick();
        tick();
        bus.i_rast_busy = 1'b1;
        tick();
        check("rst_wd_acked", 32'(bus.o_tri_valid), 32'd0);
        tick();
        rst = 1'b1;
        bus.i_rast_busy = 1'b0;
        tick();
        check_reset_outputs("rst_wd");
        rst = 1'b0;
        dn = done_cnt;
        repeat (30) tick();
        check("rst_wd_nodone", 32'(done_cnt - dn), 32'd0);
        check("rst_wd_valid_lo", 32'(bus.o_tri_valid), 32'd0);
        check("rst_wd_idle", 32'(bus.o_busy), 32'd0);

        // Full frame after the aborted ones.
        w = wr_cnt;
        start_frame(8'd0, acc);
        wait_done(NP + 100, at);
        check("post_latency", 32'(at - acc), 32'(NP + D + 2));
        check("post_writes", 32'(wr_cnt - w), 32'(NP));
        check("post_contig", 32'(addr_bad), 32'd0);
        check("post_pixel", 32'(pix_bad), 32'd0);
        check("addr_range", 32'(over_cnt), 32'd0);
        check("no_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
